bb_txsched: RTL and testbench
=============================

BB_TXSCHED -- requirements
Module: bb_txsched

Interface
REQ-001 SHALL have clk_6M  input  1  6 MHz baseband clock; all state on its rising edge.
REQ-002 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ms_tslot_p  input  1  one-cycle pulse at each 625 us slot boundary.
REQ-004 SHALL have conns  input  1  connection state active.
REQ-005 SHALL have regi_isMaster  input  1  device is master; scheduling only when 1.
REQ-006 SHALL have regi_sco_en  input  1  SCO link enabled.
REQ-007 SHALL have regi_Tsco  input  8  SCO interval in slots (even, 2..254).
REQ-008 SHALL have regi_Dsco  input  8  SCO offset in slots (even, < regi_Tsco).
REQ-009 SHALL have regi_Tpoll  input  8  poll interval in TX opportunities; 0 disables polling.
REQ-010 SHALL have lmp_req, acl_retx_req, acl_new_req  inputs  1 each  pending levels.
REQ-011 SHALL have occupy_slots  input  3  slots of the pending ACL/LMP packet (1, 3, 5).
REQ-012 SHALL have txcmd_p  output  1  one-cycle transmit-start pulse.
REQ-013 SHALL have txsel  output  3  0 none, 1 SCO, 2 LMP, 3 ACL retx, 4 ACL new, 5 POLL.
REQ-014 SHALL have tx_reservedslot, rx_reservedslot  outputs  1 each  current slot reserved for SCO TX / RX.
REQ-015 SHALL have txtsco_p  output  1  pulse coinciding with txcmd_p when txsel=1.
REQ-016 SHALL have busy  output  1  a multi-slot transmission is in progress.

Function
REQ-017 SHALL keep a slot parity bit, toggling on each ms_tslot_p while conns=1 and cleared while conns=0; ms_tslot_p with parity=0 is a TX opportunity.
REQ-018 SHALL keep an 8-bit slot counter, incremented on each ms_tslot_p and wrapped from regi_Tsco-1 to 0; held at 0 while conns=0 or regi_sco_en=0.
REQ-019 SHALL classify a TX opportunity as reserved when regi_sco_en=1 and slot counter == regi_Dsco.
REQ-020 SHALL implement states IDLE, ARM, TXMULTI, RXSLOT.
REQ-021 IDLE -> ARM when conns & regi_isMaster; any state -> IDLE within one cycle when either drops, with all outputs zeroed.
REQ-022 In ARM, at a TX opportunity SHALL select by fixed priority SCO (reserved) > LMP > ACL retx > ACL new > POLL > none.
REQ-023 SHALL assert txcmd_p exactly one cycle after the selecting ms_tslot_p, and not at all when the selection is none.
REQ-024 SHALL hold txsel from txcmd_p until the next ms_tslot_p, then return it to 0.
REQ-025 For LMP/ACL with occupy_slots=3 or 5, SHALL go to TXMULTI, set busy, and suppress selection until occupy_slots ms_tslot_p pulses have elapsed; then RXSLOT.
REQ-026 For SCO, POLL or single-slot packets, SHALL go to RXSLOT; RXSLOT returns to ARM on the next ms_tslot_p.
REQ-027 A reserved opportunity falling inside TXMULTI SHALL be lost (no deferral); in-flight ACL is never truncated.
REQ-028 SHALL drive tx_reservedslot during a reserved TX slot and rx_reservedslot during the slot that immediately follows it.
REQ-029 occupy_slots values other than 3 or 5 SHALL be treated as 1.
REQ-030 Request levels SHALL be sampled only on the selecting ms_tslot_p; later changes do not alter txsel.

Reset
REQ-031 On rst: state IDLE; parity, slot counter, poll timer, txcmd_p, txsel, tx_reservedslot, rx_reservedslot, txtsco_p, busy all 0.
REQ-032 rst asserted mid-transmission SHALL abort immediately with no further txcmd_p until conns and regi_isMaster are reasserted after release.

Configuration
REQ-033 Macro BB_TXSCHED_POLL_EN defined: 8-bit poll timer counts TX opportunities with no LMP/ACL selection; POLL selected when the timer >= regi_Tpoll != 0 and nothing higher is pending; timer clears on any LMP/ACL/POLL selection, saturates at 255.
REQ-034 Macro undefined: no poll timer; txsel never equals 5; regi_Tpoll ignored.

Verification
REQ-035 Tsco=6, Dsco=2, sco_en=1, no ACL -> txsel=1 plus txtsco_p every 6 slots starting at counter 2; rx_reservedslot in the following slot.
REQ-036 acl_new_req=1, occupy_slots=5 -> one txcmd_p, busy for 5 slots, next txcmd_p no earlier than slot 6 (TX opportunity after RXSLOT).
REQ-037 lmp_req, acl_retx_req, acl_new_req all 1 at a non-reserved opportunity -> txsel=2; on a reserved one -> txsel=1.
REQ-038 POLL_EN, Tpoll=4, idle link -> txsel=5 on every 4th TX opportunity; without the macro -> no txcmd_p.
REQ-039 conns deasserted during TXMULTI -> busy=0, txsel=0 next cycle, state IDLE; rst pulse mid-TX -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bb_txsched_if.sv
// Scheduler port bundle: slot timing, link config and request levels in; transmit command out.
// master = scheduler side, slave = link-controller side.
interface bb_txsched_if;
   localparam int unsigned SLOT_W = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned OCC_W  = 3;

   logic              ms_tslot_p;
   logic              conns;
   logic              regi_isMaster;
   logic              regi_sco_en;
   logic [SLOT_W-1:0] regi_Tsco;
   logic [SLOT_W-1:0] regi_Dsco;
   logic [SLOT_W-1:0] regi_Tpoll;
   logic              lmp_req;
   logic              acl_retx_req;
   logic              acl_new_req;
   logic [OCC_W-1:0]  occupy_slots;

   logic              txcmd_p;
   logic [SEL_W-1:0]  txsel;
   logic              tx_reservedslot;
   logic              rx_reservedslot;
   logic              txtsco_p;
   logic              busy;

   modport master (
      input  ms_tslot_p, conns, regi_isMaster, regi_sco_en, regi_Tsco, regi_Dsco,
             regi_Tpoll, lmp_req, acl_retx_req, acl_new_req, occupy_slots,
      output txcmd_p, txsel, tx_reservedslot, rx_reservedslot, txtsco_p, busy
   );

   modport slave (
      output ms_tslot_p, conns, regi_isMaster, regi_sco_en, regi_Tsco, regi_Dsco,
             regi_Tpoll, lmp_req, acl_retx_req, acl_new_req, occupy_slots,
      input  txcmd_p, txsel, tx_reservedslot, rx_reservedslot, txtsco_p, busy
   );
endinterface

// File: rtl/bb_txsched.sv
// Master-side baseband TX slot scheduler: SCO reservation, LMP/ACL priority, multi-slot hold.
// Define BB_TXSCHED_POLL_EN to add the POLL timer (txsel=5); otherwise regi_Tpoll is ignored.
module bb_txsched (
   input  logic         clk_6M,
   input  logic         rst,
   bb_txsched_if.master bus
);
   localparam int unsigned SLOT_W = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned REM_W  = 3;

   localparam logic [SEL_W-1:0] SEL_NONE = 3'd0;
   localparam logic [SEL_W-1:0] SEL_SCO  = 3'd1;
   localparam logic [SEL_W-1:0] SEL_LMP  = 3'd2;
   localparam logic [SEL_W-1:0] SEL_RETX = 3'd3;
   localparam logic [SEL_W-1:0] SEL_NEW  = 3'd4;
   localparam logic [SEL_W-1:0] SEL_POLL = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_TXMULTI = 2'd2,
      ST_RXSLOT  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              parity_q, parity_d;
   logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic              rearm_wait_q, rearm_wait_d;
   logic              txcmd_q, txcmd_d;
   logic [SEL_W-1:0]  txsel_q, txsel_d;
   logic              txres_q, txres_d;
   logic              rxres_q, rxres_d;
   logic              txtsco_q, txtsco_d;
   logic              busy_q, busy_d;

   logic              link_ok_c;
   logic              tx_opp_c;
   logic              reserved_c;
   logic              multi_c;
   logic              poll_due_c;
   logic [SEL_W-1:0]  sel_c;

   assign link_ok_c  = bus.conns & bus.regi_isMaster;
   assign tx_opp_c   = bus.ms_tslot_p & bus.conns & ~parity_q;
   assign reserved_c = bus.regi_sco_en & (slot_cnt_q == bus.regi_Dsco);
   assign multi_c    = (bus.occupy_slots == 3'd3) || (bus.occupy_slots == 3'd5);

   // Fixed-priority pick for the current TX opportunity
   always_comb begin
      sel_c = SEL_NONE;
      if (reserved_c)            sel_c = SEL_SCO;
      else if (bus.lmp_req)      sel_c = SEL_LMP;
      else if (bus.acl_retx_req) sel_c = SEL_RETX;
      else if (bus.acl_new_req)  sel_c = SEL_NEW;
      else if (poll_due_c)       sel_c = SEL_POLL;
   end

`ifdef BB_TXSCHED_POLL_EN
   logic [SLOT_W-1:0] poll_q, poll_d, poll_inc_c;

   // The current opportunity counts toward the interval before comparing
   assign poll_inc_c = (poll_q == '1) ? poll_q : poll_q + SLOT_W'(1);
   assign poll_due_c = (bus.regi_Tpoll != '0) && (poll_inc_c >= bus.regi_Tpoll);

   always_comb begin
      poll_d = poll_q;
      if (!link_ok_c || state_q == ST_IDLE) begin
         poll_d = '0;
      end else if (state_q == ST_ARM && tx_opp_c) begin
         if (sel_c != SEL_NONE && sel_c != SEL_SCO) poll_d = '0;
         else                                      poll_d = poll_inc_c;
      end
   end

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) poll_q <= '0;
      else     poll_q <= poll_d;
   end
`else
   logic unused_tpoll;
   assign poll_due_c  = 1'b0;
   assign unused_tpoll = ^bus.regi_Tpoll;
`endif

   always_comb begin
      state_d      = state_q;
      parity_d     = parity_q;
      slot_cnt_d   = slot_cnt_q;
      rem_d        = rem_q;
      rearm_wait_d = rearm_wait_q;
      txcmd_d      = 1'b0;
      txsel_d      = txsel_q;
      txres_d      = txres_q;
      rxres_d      = rxres_q;
      txtsco_d     = 1'b0;
      busy_d       = busy_q;

      if (!bus.conns)           parity_d = 1'b0;
      else if (bus.ms_tslot_p)  parity_d = ~parity_q;

      if (!bus.conns || !bus.regi_sco_en) begin
         slot_cnt_d = '0;
      end else if (bus.ms_tslot_p) begin
         slot_cnt_d = (slot_cnt_q >= bus.regi_Tsco - SLOT_W'(1)) ? '0 : slot_cnt_q + SLOT_W'(1);
      end

      // Slot boundary: selection and TX reservation expire, RX reservation follows TX
      if (bus.ms_tslot_p) begin
         txsel_d = SEL_NONE;
         txres_d = 1'b0;
         rxres_d = txres_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (link_ok_c && !rearm_wait_q) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (tx_opp_c && sel_c != SEL_NONE) begin
               txcmd_d  = 1'b1;
               txsel_d  = sel_c;
               txtsco_d = (sel_c == SEL_SCO);
               txres_d  = (sel_c == SEL_SCO);
               if (sel_c != SEL_SCO && sel_c != SEL_POLL && multi_c) begin
                  state_d = ST_TXMULTI;
                  busy_d  = 1'b1;
                  rem_d   = REM_W'(bus.occupy_slots - 3'd1);
               end else begin
                  state_d = ST_RXSLOT;
               end
            end
         end
         ST_TXMULTI: begin
            if (bus.ms_tslot_p) begin
               if (rem_q <= REM_W'(1)) begin
                  state_d = ST_RXSLOT;
                  rem_d   = '0;
               end else begin
                  rem_d   = rem_q - REM_W'(1);
               end
            end
         end
         ST_RXSLOT: begin
            if (bus.ms_tslot_p) begin
               state_d = ST_ARM;
               busy_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Losing the link or master role aborts everything, in-flight packets included
      if (!link_ok_c) begin
         state_d      = ST_IDLE;
         rem_d        = '0;
         rearm_wait_d = 1'b0;
         txcmd_d      = 1'b0;
         txsel_d      = SEL_NONE;
         txres_d      = 1'b0;
         rxres_d      = 1'b0;
         txtsco_d     = 1'b0;
         busy_d       = 1'b0;
      end
   end

   // A reset blocks re-arming until the link has been seen down once
   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         parity_q     <= 1'b0;
         slot_cnt_q   <= '0;
         rem_q        <= '0;
         rearm_wait_q <= 1'b1;
         txcmd_q      <= 1'b0;
         txsel_q      <= SEL_NONE;
         txres_q      <= 1'b0;
         rxres_q      <= 1'b0;
         txtsco_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         parity_q     <= parity_d;
         slot_cnt_q   <= slot_cnt_d;
         rem_q        <= rem_d;
         rearm_wait_q <= rearm_wait_d;
         txcmd_q      <= txcmd_d;
         txsel_q      <= txsel_d;
         txres_q      <= txres_d;
         rxres_q      <= rxres_d;
         txtsco_q     <= txtsco_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.txcmd_p         = txcmd_q;
   assign bus.txsel           = txsel_q;
   assign bus.tx_reservedslot = txres_q;
   assign bus.rx_reservedslot = rxres_q;
   assign bus.txtsco_p        = txtsco_q;
   assign bus.busy            = busy_q;

endmodule

// File: tb/tb_bb_txsched.sv
// Self-checking bench for bb_txsched: slot-level reference model driven by random request levels.
module tb_bb_txsched;
   localparam int unsigned SLOT_CYC = 8;
`ifdef BB_TXSCHED_POLL_EN
   localparam bit POLL_EN = 1'b1;
`else
   localparam bit POLL_EN = 1'b0;
`endif

   typedef struct packed {
      logic       txcmd;
      logic [2:0] txsel;
      logic       txtsco;
      logic       txres;
      logic       rxres;
      logic       busy;
      logic       txcmd2;
      logic [2:0] txsel_late;
   } slot_t;

   logic clk_6M = 1'b0;
   logic rst;

   bb_txsched_if bus ();
   bb_txsched dut (.clk_6M(clk_6M), .rst(rst), .bus(bus));

   always #5 clk_6M = ~clk_6M;

   int n_vec = 0;
   int n_err = 0;

   // Slot-level model: slot index since link-up, earliest slot a new pick may start
   int m_s, m_free_from, m_busy_end, m_poll, m_cnt;
   bit m_par, m_prev_sco;

   function automatic void model_reset();
      m_s = 0; m_free_from = 0; m_busy_end = 0; m_poll = 0; m_cnt = 0;
      m_par = 1'b0; m_prev_sco = 1'b0;
   endfunction

   function automatic slot_t model_slot();
      slot_t e;
      int    sel, n, pinc;
      bit    res, due;
      e   = '0;
      sel = 0;
      res = bus.regi_sco_en && (m_cnt == int'(bus.regi_Dsco));
      if (!m_par && m_s >= m_free_from) begin
         pinc = (m_poll < 255) ? m_poll + 1 : 255;
         due  = POLL_EN && (bus.regi_Tpoll != 8'd0) && (pinc >= int'(bus.regi_Tpoll));
         if (res)                   sel = 1;
         else if (bus.lmp_req)      sel = 2;
         else if (bus.acl_retx_req) sel = 3;
         else if (bus.acl_new_req)  sel = 4;
         else if (due)              sel = 5;
         m_poll = (sel >= 2) ? 0 : pinc;
         if (sel != 0) begin
            n = (sel >= 2 && sel <= 4 && (bus.occupy_slots == 3'd3 || bus.occupy_slots == 3'd5))
                ? int'(bus.occupy_slots) : 1;
            m_free_from = m_s + n + 1;
            if (n > 1) m_busy_end = m_s + n;
         end
      end
      e.txcmd      = (sel != 0);
      e.txsel      = 3'(sel);
      e.txtsco     = (sel == 1);
      e.txres      = (sel == 1);
      e.rxres      = m_prev_sco;
      e.busy       = (m_s < m_busy_end);
      e.txcmd2     = 1'b0;
      e.txsel_late = 3'(sel);
      m_prev_sco   = (sel == 1);
      m_par        = !m_par;
      m_cnt        = bus.regi_sco_en ? (m_cnt + 1) % int'(bus.regi_Tsco) : 0;
      m_s++;
      return e;
   endfunction

   function automatic slot_t sample_now();
      slot_t o;
      o = '0;
      o.txcmd = bus.txcmd_p;  o.txsel = bus.txsel;  o.txtsco = bus.txtsco_p;
      o.txres = bus.tx_reservedslot;  o.rxres = bus.rx_reservedslot;  o.busy = bus.busy;
      o.txcmd2 = bus.txcmd_p;  o.txsel_late = bus.txsel;
      return o;
   endfunction

   task automatic rand_reqs();
      bus.lmp_req      = ($urandom_range(0, 3) == 0);
      bus.acl_retx_req = ($urandom_range(0, 9) < 3);
      bus.acl_new_req  = ($urandom_range(0, 1) == 1);
      bus.occupy_slots = 3'($urandom_range(0, 7));
   endtask

   // One slot: pulse, expected from the model at the pulse, samples just after and late in the slot
   task automatic slot_step(input bit rand_req, output slot_t o, output slot_t e);
      o = '0;
      @(negedge clk_6M);
      bus.ms_tslot_p = 1'b1;
      e = model_slot();
      @(negedge clk_6M);
      bus.ms_tslot_p = 1'b0;
      o.txcmd = bus.txcmd_p;  o.txsel = bus.txsel;  o.txtsco = bus.txtsco_p;
      o.txres = bus.tx_reservedslot;  o.rxres = bus.rx_reservedslot;  o.busy = bus.busy;
      if (rand_req) rand_reqs();
      @(negedge clk_6M);
      o.txcmd2 = bus.txcmd_p;
      repeat (SLOT_CYC - 3) @(negedge clk_6M);
      o.txsel_late = bus.txsel;
   endtask

   task automatic link_down();
      @(negedge clk_6M);
      bus.conns = 1'b0;
      bus.regi_isMaster = 1'b0;
      repeat (2) @(negedge clk_6M);
      model_reset();
   endtask

   task automatic link_up();
      @(negedge clk_6M);
      bus.conns = 1'b1;
      bus.regi_isMaster = 1'b1;
      @(negedge clk_6M);
   endtask

   task automatic set_reqs(input bit lmp, input bit retx, input bit anew, input logic [2:0] occ);
      bus.lmp_req = lmp; bus.acl_retx_req = retx; bus.acl_new_req = anew; bus.occupy_slots = occ;
   endtask

   task automatic test_reset();
      slot_t o, e;
      rst = 1'b1;
      repeat (3) @(negedge clk_6M);
      o = sample_now();
      n_vec++;
      if (o !== slot_t'(0)) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", o);
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== slot_t'(0)) begin
            n_err++; $display("FAIL reset_no_link slot %0d: got %h want 0", i, o);
         end
      end
   endtask

   task automatic test_sco();
      slot_t o, e;
      int n_sco = 0, first_sco = -1;
      link_down();
      bus.regi_Tsco = 8'd6; bus.regi_Dsco = 8'd2; bus.regi_sco_en = 1'b1; bus.regi_Tpoll = 8'd0;
      set_reqs(1'b0, 1'b0, 1'b0, 3'd1);
      link_up();
      for (int i = 0; i < 18; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== e) begin
            n_err++; $display("FAIL sco slot %0d: got %h want %h", i, o, e);
         end
         if (o.txtsco) begin
            n_sco++;
            if (first_sco < 0) first_sco = i;
         end
      end
      n_vec++;
      if (n_sco !== 3 || first_sco !== 2) begin
         n_err++; $display("FAIL sco_schedule: got count %0d first %0d want 3 first 2", n_sco, first_sco);
      end
   endtask

   task automatic test_multislot();
      slot_t o, e;
      int n_tx = 0;
      logic busy4 = 1'b0, busy5 = 1'b1;
      link_down();
      bus.regi_sco_en = 1'b0;
      set_reqs(1'b0, 1'b0, 1'b1, 3'd5);
      link_up();
      for (int i = 0; i < 14; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== e) begin
            n_err++; $display("FAIL multislot slot %0d: got %h want %h", i, o, e);
         end
         if (o.txcmd) n_tx++;
         if (i == 4) busy4 = o.busy;
         if (i == 5) busy5 = o.busy;
      end
      n_vec++;
      if (n_tx !== 3 || busy4 !== 1'b1 || busy5 !== 1'b0) begin
         n_err++; $display("FAIL multislot_span: got tx %0d busy4 %b busy5 %b want 3 1 0", n_tx, busy4, busy5);
      end
   endtask

   task automatic test_priority();
      slot_t o, e;
      logic [2:0] sel0 = 3'd0, sel2 = 3'd0;
      link_down();
      bus.regi_Tsco = 8'd4; bus.regi_Dsco = 8'd0; bus.regi_sco_en = 1'b1;
      set_reqs(1'b1, 1'b1, 1'b1, 3'd1);
      link_up();
      for (int i = 0; i < 8; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== e) begin
            n_err++; $display("FAIL priority slot %0d: got %h want %h", i, o, e);
         end
         if (i == 0) sel0 = o.txsel;
         if (i == 2) sel2 = o.txsel;
      end
      n_vec++;
      if (sel0 !== 3'd1 || sel2 !== 3'd2) begin
         n_err++; $display("FAIL priority_order: got %0d,%0d want 1,2", sel0, sel2);
      end
   endtask

   task automatic test_random();
      slot_t o, e;
      int t;
      for (int r = 0; r < 3; r++) begin
         link_down();
         t = 2 * int'($urandom_range(1, 5));
         bus.regi_Tsco   = 8'(t);
         bus.regi_Dsco   = 8'(2 * int'($urandom_range(0, t / 2 - 1)));
         bus.regi_sco_en = ($urandom_range(0, 3) != 0);
         bus.regi_Tpoll  = 8'($urandom_range(0, 5));
         rand_reqs();
         link_up();
         for (int i = 0; i < 80; i++) begin
            slot_step(1'b1, o, e);
            n_vec++;
            if (o !== e) begin
               n_err++; $display("FAIL random r%0d slot %0d: got %h want %h", r, i, o, e);
            end
         end
      end
   endtask

   task automatic test_poll();
      slot_t o, e;
      int n_tx = 0;
      link_down();
      bus.regi_sco_en = 1'b0; bus.regi_Tpoll = 8'd4;
      set_reqs(1'b0, 1'b0, 1'b0, 3'd1);
      link_up();
      for (int i = 0; i < 24; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== e) begin
            n_err++; $display("FAIL poll slot %0d: got %h want %h", i, o, e);
         end
         if (o.txcmd) n_tx++;
      end
      n_vec++;
      if (n_tx !== (POLL_EN ? 3 : 0)) begin
         n_err++; $display("FAIL poll_count: got %0d want %0d", n_tx, POLL_EN ? 3 : 0);
      end
      bus.regi_Tpoll = 8'd0;
   endtask

   task automatic test_abort();
      slot_t o, e;
      link_down();
      bus.regi_sco_en = 1'b0;
      set_reqs(1'b0, 1'b0, 1'b1, 3'd5);
      link_up();
      slot_step(1'b0, o, e);
      n_vec++;
      if (bus.busy !== 1'b1 || bus.txsel !== 3'd4) begin
         n_err++; $display("FAIL abort_pre: got busy %b txsel %0d want 1 4", bus.busy, bus.txsel);
      end
      bus.conns = 1'b0;
      @(negedge clk_6M);
      o = sample_now();
      n_vec++;
      if (o !== slot_t'(0)) begin
         n_err++; $display("FAIL abort_conns: got %h want 0", o);
      end
      for (int i = 0; i < 3; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== slot_t'(0)) begin
            n_err++; $display("FAIL abort_idle slot %0d: got %h want 0", i, o);
         end
      end
   endtask

   task automatic test_rst_mid_tx();
      slot_t o, e;
      link_down();
      bus.regi_sco_en = 1'b0;
      set_reqs(1'b0, 1'b0, 1'b1, 3'd5);
      link_up();
      slot_step(1'b0, o, e);
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++; $display("FAIL rst_pre_busy: got %b want 1", bus.busy);
      end
      #2 rst = 1'b1;
      #1 o = sample_now();
      n_vec++;
      if (o !== slot_t'(0)) begin
         n_err++; $display("FAIL rst_async: got %h want 0", o);
      end
      @(negedge clk_6M);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== slot_t'(0)) begin
            n_err++; $display("FAIL rst_no_rearm slot %0d: got %h want 0", i, o);
         end
      end
      link_down();
      link_up();
      for (int i = 0; i < 8; i++) begin
         slot_step(1'b0, o, e);
         n_vec++;
         if (o !== e || (i == 0 && o.txcmd !== 1'b1)) begin
            n_err++; $display("FAIL rst_resume slot %0d: got %h want %h", i, o, e);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.ms_tslot_p = 1'b0; bus.conns = 1'b0; bus.regi_isMaster = 1'b0;
      bus.regi_sco_en = 1'b0; bus.regi_Tsco = 8'd6; bus.regi_Dsco = 8'd2; bus.regi_Tpoll = 8'd0;
      set_reqs(1'b0, 1'b0, 1'b0, 3'd1);
      model_reset();
      test_reset();
      test_sco();
      test_multislot();
      test_priority();
      test_random();
      test_poll();
      test_abort();
      test_rst_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
